nibble_rx_requester: RTL and testbench

Requesting end of the 4-bit parallel Req/Ack nibble link that carries 12-bit samples. It drives Req, captures DataIn on each Ack, and assembles three nibbles (LSN first) into one 12-bit word. It sits in the consumer domain: the FPGA-to-FPGA link, the loopback test harness and the ESP-side model. It pairs with the existing nibble transmitter, which presents [3:0], then [7:4], then [11:8], each with Ack high.

---
 rtl/nibble_rx_requester.sv | 182 ++++++++++++++++++
 tb/tb_nibble_rx_requester.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_rx_requester.sv
// nibble_rx_requester
//   Requesting end of the 4-bit Req/Ack nibble link. Each Start fetches one
//   12-bit word as three full four-phase handshakes, least significant nibble
//   first, and presents it on RxData with a one-cycle RxValid pulse. A
//   per-phase watchdog aborts a stalled handshake with a one-cycle RxErr pulse.
//
//   Optional build macro ACK_SYNC_EN: when defined, Ack and DataIn pass through
//   a 2-flop synchroniser (responder on a foreign clock). When undefined they
//   are sampled directly (responder on ExtClk).
//
// Parameters
//   TIMEOUT_CYCLES : max cycles waiting for one Ack level change; 0 disables
//   TO_W           : timeout counter width, must hold TIMEOUT_CYCLES
// Ports
//   ExtClk, ExtReset : clock, asynchronous active-high reset
//   Start            : one-cycle fetch request, honoured only while Ready=1
//   Ready, Busy      : idle with Ack low / not idle
//   Req, Ack, DataIn : link handshake and nibble data
//   RxData, RxValid  : last completed word, one-cycle update strobe
//   RxErr            : one-cycle timeout abort strobe
module nibble_rx_requester #(
   parameter int unsigned TIMEOUT_CYCLES = 1023,
   parameter int unsigned TO_W           = 10
) (
   input  logic        ExtClk,
   input  logic        ExtReset,
   input  logic        Start,
   output logic        Ready,
   output logic        Busy,
   output logic        Req,
   input  logic        Ack,
   input  logic [3:0]  DataIn,
   output logic [11:0] RxData,
   output logic        RxValid,
   output logic        RxErr
);

   typedef enum logic [1:0] {StIdle, StWaitHi, StWaitLo} state_e;

   localparam bit            ToEn    = (TIMEOUT_CYCLES != 0);
   localparam logic [TO_W:0] ToLimit = (TO_W + 1)'(TIMEOUT_CYCLES);

   state_e            state_q, state_d;
   logic              req_q, req_d;
   logic [1:0]        nib_cnt_q, nib_cnt_d;
   logic [11:0]       asm_q, asm_d;
   logic [11:0]       rx_data_q, rx_data_d;
   logic              rx_valid_q, rx_valid_d;
   logic              rx_err_q, rx_err_d;
   logic [TO_W-1:0]   to_q, to_d;
   logic [TO_W:0]     to_inc;
   logic              ack_s;
   logic [3:0]        data_s;

`ifdef ACK_SYNC_EN
   // Data rides the same two stages as Ack so a nibble is never paired with
   // the wrong Ack edge.
   logic       ack_meta_q, ack_sync_q;
   logic [3:0] data_meta_q, data_sync_q;

   always_ff @(posedge ExtClk or posedge ExtReset) begin
      if (ExtReset) begin
         ack_meta_q  <= 1'b0;
         ack_sync_q  <= 1'b0;
         data_meta_q <= 4'h0;
         data_sync_q <= 4'h0;
      end else begin
         ack_meta_q  <= Ack;
         ack_sync_q  <= ack_meta_q;
         data_meta_q <= DataIn;
         data_sync_q <= data_meta_q;
      end
   end

   assign ack_s  = ack_sync_q;
   assign data_s = data_sync_q;
`else
   assign ack_s  = Ack;
   assign data_s = DataIn;
`endif

   assign to_inc = {1'b0, to_q} + (TO_W + 1)'(1);

   always_comb begin
      state_d    = state_q;
      req_d      = req_q;
      nib_cnt_d  = nib_cnt_q;
      asm_d      = asm_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      rx_err_d   = 1'b0;
      to_d       = to_q;

      unique case (state_q)
         StIdle: begin
            to_d = '0;
            if (Start && !ack_s) begin
               state_d   = StWaitHi;
               req_d     = 1'b1;
               nib_cnt_d = 2'd0;
               asm_d     = 12'h000;
            end
         end
         StWaitHi: begin
            if (ack_s) begin
               case (nib_cnt_q)
                  2'd0:    asm_d[3:0]  = data_s;
                  2'd1:    asm_d[7:4]  = data_s;
                  default: asm_d[11:8] = data_s;
               endcase
               req_d   = 1'b0;
               state_d = StWaitLo;
               to_d    = '0;
            end else if (ToEn && (to_inc == ToLimit)) begin
               req_d    = 1'b0;
               rx_err_d = 1'b1;
               state_d  = StIdle;
               to_d     = '0;
            end else begin
               to_d = to_inc[TO_W-1:0];
            end
         end
         StWaitLo: begin
            if (!ack_s) begin
               to_d = '0;
               if (nib_cnt_q == 2'd2) begin
                  // asm_q already holds the newest nibble from WAIT_HI.
                  rx_data_d  = asm_q;
                  rx_valid_d = 1'b1;
                  state_d    = StIdle;
               end else begin
                  nib_cnt_d = nib_cnt_q + 2'd1;
                  req_d     = 1'b1;
                  state_d   = StWaitHi;
               end
            end else if (ToEn && (to_inc == ToLimit)) begin
               req_d    = 1'b0;
               rx_err_d = 1'b1;
               state_d  = StIdle;
               to_d     = '0;
            end else begin
               to_d = to_inc[TO_W-1:0];
            end
         end
         default: begin
            state_d = StIdle;
            req_d   = 1'b0;
            to_d    = '0;
         end
      endcase
   end

   always_ff @(posedge ExtClk or posedge ExtReset) begin
      if (ExtReset) begin
         state_q    <= StIdle;
         req_q      <= 1'b0;
         nib_cnt_q  <= 2'd0;
         asm_q      <= 12'h000;
         rx_data_q  <= 12'h000;
         rx_valid_q <= 1'b0;
         rx_err_q   <= 1'b0;
         to_q       <= '0;
      end else begin
         state_q    <= state_d;
         req_q      <= req_d;
         nib_cnt_q  <= nib_cnt_d;
         asm_q      <= asm_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         rx_err_q   <= rx_err_d;
         to_q       <= to_d;
      end
   end

   assign Ready   = (state_q == StIdle) && !ack_s;
   assign Busy    = (state_q != StIdle);
   assign Req     = req_q;
   assign RxData  = rx_data_q;
   assign RxValid = rx_valid_q;
   assign RxErr   = rx_err_q;

endmodule

// File: tb/tb_nibble_rx_requester.sv
module tb_nibble_rx_requester;

   // Three handshakes of 4 cycles each; the synchroniser adds 2 per Ack edge.
`ifdef ACK_SYNC_EN
   localparam int Lat = 24;
`else
   localparam int Lat = 12;
`endif
   localparam int ToCycles = 15;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        ready, busy, req;
   logic        ack;
   logic [11:0] rx_data;
   logic        rx_valid, rx_err;

   // Same-clock responder model
   logic [11:0] resp_word;
   logic        resp_en;
   logic        force_hi;
   logic        resp_ack;
   logic [3:0]  resp_data;
   int          resp_idx;

   // Monitors
   logic        req_prev;
   int          req_rises;
   int          valid_cnt;
   int          overlap;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   assign ack = force_hi | resp_ack;

   nibble_rx_requester #(
      .TIMEOUT_CYCLES(ToCycles),
      .TO_W          (10)
   ) dut (
      .ExtClk  (clk),
      .ExtReset(rst),
      .Start   (start),
      .Ready   (ready),
      .Busy    (busy),
      .Req     (req),
      .Ack     (ack),
      .DataIn  (resp_data),
      .RxData  (rx_data),
      .RxValid (rx_valid),
      .RxErr   (rx_err)
   );

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         resp_ack  <= 1'b0;
         resp_idx  <= 0;
         resp_data <= 4'h0;
      end else if (resp_en) begin
         if (req && !resp_ack) begin
            resp_ack  <= 1'b1;
            resp_data <= resp_word[resp_idx*4 +: 4];
         end else if (!req && resp_ack) begin
            resp_ack <= 1'b0;
            resp_idx <= (resp_idx == 2) ? 0 : resp_idx + 1;
         end
      end
   end

   initial begin
      req_prev  = 1'b0;
      req_rises = 0;
      valid_cnt = 0;
      overlap   = 0;
   end

   always @(posedge clk) begin
      req_prev <= req;
      if (req && !req_prev) req_rises <= req_rises + 1;
      if (rx_valid) valid_cnt <= valid_cnt + 1;
      if (rx_valid && rx_err) overlap <= overlap + 1;
   end

   // Caller is positioned #1 after a rising edge. lat = cycles from the edge
   // that accepts Start to the first sample showing RxValid; -1 on no result.
   task automatic run_word(input logic [11:0] w, input logic hold_start, output int lat);
      resp_word = w;
      start     = 1'b1;
      @(posedge clk); #1;
      if (!hold_start) start = 1'b0;
      lat = -1;
      for (int i = 1; i <= 200; i++) begin
         @(posedge clk); #1;
         if (rx_valid) begin
            lat = i;
            break;
         end
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; resp_en = 1'b1; force_hi = 1'b0; resp_word = 12'h000;
      #3;
      checks++;
      if (req !== 1'b0 || busy !== 1'b0 || rx_valid !== 1'b0 || rx_err !== 1'b0) begin
         failures++;
         $display("FAIL reset_ctrl got req=%b busy=%b valid=%b err=%b exp all 0",
                  req, busy, rx_valid, rx_err);
      end
      checks++;
      if (rx_data !== 12'h000 || ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_data got rx_data=%h ready=%b exp 000 1", rx_data, ready);
      end
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_single_word();
      int lat;
      int r0;
      r0 = req_rises;
      run_word(12'hA5C, 1'b0, lat);
      checks++;
      if (lat !== Lat) begin
         failures++;
         $display("FAIL single_latency got=%0d exp=%0d", lat, Lat);
      end
      checks++;
      if (rx_data !== 12'hA5C) begin
         failures++;
         $display("FAIL single_data got=%h exp=a5c", rx_data);
      end
      @(posedge clk); #1;
      checks++;
      if (rx_valid !== 1'b0) begin
         failures++;
         $display("FAIL single_valid_width got=%b exp=0", rx_valid);
      end
      checks++;
      if (busy !== 1'b0 || ready !== 1'b1) begin
         failures++;
         $display("FAIL single_idle got busy=%b ready=%b exp 0 1", busy, ready);
      end
      checks++;
      if (req_rises - r0 !== 3) begin
         failures++;
         $display("FAIL single_req_pulses got=%0d exp=3", req_rises - r0);
      end
   endtask

   task automatic test_back_to_back();
      int lat1, lat2;
      int r0, v0;
      r0 = req_rises;
      v0 = valid_cnt;
      run_word(12'h123, 1'b0, lat1);
      checks++;
      if (lat1 !== Lat || rx_data !== 12'h123 || ready !== 1'b1) begin
         failures++;
         $display("FAIL b2b_first got lat=%0d data=%h ready=%b exp %0d 123 1",
                  lat1, rx_data, ready, Lat);
      end
      run_word(12'hFED, 1'b0, lat2);
      checks++;
      if (lat2 !== Lat || rx_data !== 12'hFED) begin
         failures++;
         $display("FAIL b2b_second got lat=%0d data=%h exp %0d fed", lat2, rx_data, Lat);
      end
      @(posedge clk); #1;
      checks++;
      if (req_rises - r0 !== 6 || valid_cnt - v0 !== 2) begin
         failures++;
         $display("FAIL b2b_counts got req_rises=%0d valids=%0d exp 6 2",
                  req_rises - r0, valid_cnt - v0);
      end
   endtask

   task automatic test_timeout();
      int lat;
      int v0;
      v0 = valid_cnt;
      resp_en = 1'b0;
      start   = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = -1;
      for (int i = 1; i <= 100; i++) begin
         @(posedge clk); #1;
         if (!req) begin
            lat = i;
            break;
         end
      end
      checks++;
      if (lat !== ToCycles) begin
         failures++;
         $display("FAIL timeout_req_fall got=%0d exp=%0d", lat, ToCycles);
      end
      checks++;
      if (rx_err !== 1'b1 || rx_valid !== 1'b0 || rx_data !== 12'hFED) begin
         failures++;
         $display("FAIL timeout_abort got err=%b valid=%b data=%h exp 1 0 fed",
                  rx_err, rx_valid, rx_data);
      end
      @(posedge clk); #1;
      checks++;
      if (rx_err !== 1'b0 || busy !== 1'b0 || ready !== 1'b1 || valid_cnt - v0 !== 0) begin
         failures++;
         $display("FAIL timeout_after got err=%b busy=%b ready=%b valids=%0d exp 0 0 1 0",
                  rx_err, busy, ready, valid_cnt - v0);
      end
      resp_en = 1'b1;
   endtask

   task automatic test_ignored_start();
      int lat;
      int r0;
      r0 = req_rises;
      // Start held high throughout the transfer, covering every WAIT_LO phase.
      run_word(12'h5A6, 1'b1, lat);
      checks++;
      if (lat !== Lat || rx_data !== 12'h5A6) begin
         failures++;
         $display("FAIL busy_start got lat=%0d data=%h exp %0d 5a6", lat, rx_data, Lat);
      end
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0 || req !== 1'b0 || req_rises - r0 !== 3) begin
         failures++;
         $display("FAIL busy_start_idle got busy=%b req=%b rises=%0d exp 0 0 3",
                  busy, req, req_rises - r0);
      end
      force_hi = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (ready !== 1'b0) begin
         failures++;
         $display("FAIL ackhi_ready got=%b exp=0", ready);
      end
      r0    = req_rises;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0 || req !== 1'b0 || req_rises - r0 !== 0) begin
         failures++;
         $display("FAIL ackhi_start got busy=%b req=%b rises=%0d exp 0 0 0",
                  busy, req, req_rises - r0);
      end
      force_hi = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (ready !== 1'b1) begin
         failures++;
         $display("FAIL ackhi_release got=%b exp=1", ready);
      end
   endtask

   task automatic test_ext_reset();
      int lat;
      int r0, v0;
      logic hit;
      r0  = req_rises;
      v0  = valid_cnt;
      hit = 1'b0;
      resp_word = 12'h8B4;
      start     = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
         if (req_rises - r0 == 2 && !req) begin
            hit = 1'b1;
            break;
         end
      end
      checks++;
      if (hit !== 1'b1 || busy !== 1'b1) begin
         failures++;
         $display("FAIL rst_reach_waitlo got hit=%b busy=%b exp 1 1", hit, busy);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if (req !== 1'b0 || busy !== 1'b0 || rx_data !== 12'h000 || rx_valid !== 1'b0) begin
         failures++;
         $display("FAIL rst_async got req=%b busy=%b data=%h valid=%b exp 0 0 000 0",
                  req, busy, rx_data, rx_valid);
      end
      @(posedge clk);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (valid_cnt - v0 !== 0) begin
         failures++;
         $display("FAIL rst_no_valid got=%0d exp=0", valid_cnt - v0);
      end
      run_word(12'h7E1, 1'b0, lat);
      checks++;
      if (lat !== Lat || rx_data !== 12'h7E1) begin
         failures++;
         $display("FAIL rst_recover got lat=%0d data=%h exp %0d 7e1", lat, rx_data, Lat);
      end
   endtask

   initial begin
      test_reset();
      test_single_word();
      test_back_to_back();
      test_timeout();
      test_ignored_start();
      test_ext_reset();
      checks++;
      if (overlap !== 0) begin
         failures++;
         $display("FAIL valid_err_overlap got=%0d exp=0", overlap);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Hard bound on total run time.
   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
